param_counter: RTL and testbench
================================

Name: param_counter

Overview:
Parametrised successor to the free-running 4-bit counter: a WIDTH-bit counter with programmable modulo, up/down/bounce modes, synchronous load and clear, and a registered terminal-count pulse. It sits behind the top-level pin mapping, with count driving uo_out (or a slice of it) and control driven from ui_in/uio_in. A compile-time prescaler is optional.

Parameters:
WIDTH, 8, counter and modulo/load width (legal 2..16)
PRESCALE_W, 4, prescaler divide-select width; used only when CNT_PRESCALE_EN is defined

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; no step when 0
clr  input  1  synchronous clear, highest priority
load  input  1  synchronous load of load_val
load_val  input  WIDTH  value written on load
mode  input  2  00 up, 01 down, 10 bounce (up/down), 11 hold
modulo  input  WIDTH  terminal value; count range 0..modulo
count  output  WIDTH  current count (registered)
dir  output  1  current direction, 1 = up, 0 = down (registered)
tc  output  1  terminal-count pulse (registered, one cycle)

Behaviour:
- Reset (rst_n low, asynchronous): count=0, dir=1, tc=0, prescaler divider=0. Release is synchronous to the next clk edge.
- Per-edge priority: clr > load > step > hold.
- clr=1: count=0, dir=1, tc=0, divider=0. en and mode are ignored.
- load=1 (clr=0): count=load_val, tc=0, divider=0. dir is unchanged.
- step = en & tick & (mode!=11). Without the prescaler, tick=1.
- Up mode (00):
  - count>=modulo: count=0, tc=1 next cycle.
  - Otherwise count+1.
  - dir is forced to 1.
- Down mode (01):
  - count==0: count=modulo, tc=1.
  - Otherwise count-1.
  - dir is forced to 0.
- Bounce mode (10):
  - dir=1 and count>=modulo: dir=0, count=count-1 (stays 0 if modulo==0 and count==0), tc=1.
  - dir=0 and count==0: dir=1, count=1 (stays 0 if modulo==0), tc=1.
  - Otherwise step by ±1 in the current dir.
- Hold mode (11) or step=0: count and dir are held, tc=0.
- tc is high for exactly the one cycle following a wrapping or reversing step. It is 0 otherwise, including on load and clr cycles.
- Latency: count changes on the edge at which step is sampled. tc is registered alongside count and is visible in the same cycle as the wrapped value.
- Arithmetic is modulo 2^WIDTH, but the >= test makes a natural roll-over unreachable in up mode.
- Out-of-range count (count>modulo after a load or a modulo change):
  - Up mode wraps to 0 with tc on the next step.
  - Down mode decrements normally until it reaches 0.
  - Bounce with dir=1 reverses immediately.
- modulo is sampled every cycle. There are no shadow registers, so a change takes effect on the next step.
- mode change mid-count: takes effect on the next step from the current count. In up and down modes, dir updates on a step edge.
- modulo==0: count is held at 0 and tc pulses on every step.

Optional Feature:
CNT_PRESCALE_EN
- Defined:
  - Adds input port presc (PRESCALE_W bits).
  - An internal PRESCALE_W-bit divider increments on each cycle with en=1.
  - tick=1 when divider==presc, and the divider returns to 0 on that cycle. One step therefore occurs per presc+1 enabled cycles; presc=0 steps every enabled cycle.
  - en=0 freezes the divider.
  - clr, load and reset zero the divider.
  - presc lowered below the current divider value: the divider wraps through 2^PRESCALE_W before matching (no early-match logic).
- Undefined: no presc port, no divider, tick tied to 1.

Test Plan:
- Reset mid-count: WIDTH=8, up, modulo=255, run to count=0x37, pulse rst_n low between edges -> count=0, dir=1, tc=0 immediately (asynchronous, no clock needed).
- Up wrap: modulo=9, en=1, from clr -> count 0..9, then 0 with tc=1 for one cycle; tc period is 10 cycles.
- Down and load: load_val=3, mode=01 -> count 3,2,1,0, then 9 (modulo=9) with tc=1; load and clr asserted together -> count=0.
- Bounce: modulo=4 -> sequence 0,1,2,3,4,3,2,1,0,1; tc high on the cycles showing 3 (after 4) and 1 (after 0); dir toggles accordingly.
- Out-of-range load: modulo=5, load 200, up, en=1 -> next edge count=0, tc=1; hold mode (11) for 3 cycles -> count frozen, tc=0.
- Prescaler (CNT_PRESCALE_EN, presc=2): up, modulo=3 -> count increments every 3rd enabled cycle; en low for 2 cycles mid-period extends that period by 2 cycles.

Source files
------------

// File: rtl/param_counter.sv
// param_counter: WIDTH-bit up/down/bounce counter with programmable modulo, load, clear and registered tc.
// Optional prescaler: define CNT_PRESCALE_EN to add the presc input and the enable divider.
module param_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      modulo,
`ifdef CNT_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  dir,
  output logic                  tc
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  mode_e            w_mode;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_tc;
  logic             w_tc_nxt;
  logic             w_tick;
  logic             w_step;
  logic             w_at_top;
  logic             w_at_zero;

  assign w_mode    = mode_e'(mode);
  assign w_at_top  = (r_count >= modulo);
  assign w_at_zero = (r_count == '0);
  assign w_step    = en && w_tick && (w_mode != MODE_HOLD);

`ifdef CNT_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_div;
  logic [PRESCALE_W-1:0] w_div_nxt;

  // Exact-match only: lowering presc below r_div makes the divider wrap before ticking.
  always_comb begin
    w_div_nxt = r_div;
    w_tick    = 1'b0;
    if (clr || load) begin
      w_div_nxt = '0;
    end else if (en) begin
      if (r_div == presc) begin
        w_tick    = 1'b1;
        w_div_nxt = '0;
      end else begin
        w_div_nxt = r_div + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else begin
      r_div <= w_div_nxt;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_tc_nxt    = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
      w_dir_nxt   = 1'b1;
    end else if (load) begin
      w_count_nxt = load_val;
    end else if (w_step) begin
      case (w_mode)
        MODE_UP: begin
          w_dir_nxt = 1'b1;
          if (w_at_top) begin
            w_count_nxt = '0;
            w_tc_nxt    = 1'b1;
          end else begin
            w_count_nxt = r_count + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          w_dir_nxt = 1'b0;
          if (w_at_zero) begin
            w_count_nxt = modulo;
            w_tc_nxt    = 1'b1;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
        MODE_BOUNCE: begin
          // At top with count==0 implies modulo==0, so the reversal holds at 0.
          if (r_dir && w_at_top) begin
            w_dir_nxt   = 1'b0;
            w_tc_nxt    = 1'b1;
            w_count_nxt = w_at_zero ? '0 : r_count - WIDTH'(1);
          end else if (!r_dir && w_at_zero) begin
            w_dir_nxt   = 1'b1;
            w_tc_nxt    = 1'b1;
            w_count_nxt = (modulo == '0) ? '0 : WIDTH'(1);
          end else if (r_dir) begin
            w_count_nxt = r_count + WIDTH'(1);
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_dir   <= 1'b1;
      r_tc    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dir   <= w_dir_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign tc    = r_tc;

endmodule

// File: tb/tb_param_counter.sv
// Directed-vector bench for param_counter (WIDTH=8); prescaler sequence runs when CNT_PRESCALE_EN is defined.
module tb_param_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] load_val;
  logic [1:0] mode;
  logic [7:0] modulo;
  logic [7:0] count;
  logic       dir;
  logic       tc;
`ifdef CNT_PRESCALE_EN
  logic [3:0] presc;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  param_counter #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .modulo   (modulo),
`ifdef CNT_PRESCALE_EN
    .presc    (presc),
`endif
    .count    (count),
    .dir      (dir),
    .tc       (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  typedef struct {
    string      name;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       en;
    logic [1:0] mode;
    logic [7:0] modulo;
    logic [7:0] exp_count;
    logic       exp_dir;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, bit c, bit l, int lv, bit e, int m, int mo,
                              int ec, bit ed, bit et);
    vec_t r;
    r.name      = n;
    r.clr       = c;
    r.load      = l;
    r.load_val  = 8'(lv);
    r.en        = e;
    r.mode      = 2'(m);
    r.modulo    = 8'(mo);
    r.exp_count = 8'(ec);
    r.exp_dir   = ed;
    r.exp_tc    = et;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int ec, input bit ed, input bit et);
    chk({name, ".count"}, 32'(count), 32'(ec));
    chk({name, ".dir"},   32'(dir),   32'(ed));
    chk({name, ".tc"},    32'(tc),    32'(et));
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bc[10] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
    bit bd[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit bt[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    // Up wrap, modulo 9
    vecs.push_back(mk("up_clr", 1, 0, 0, 0, 0, 9, 0, 1, 0));
    for (int k = 1; k <= 9; k++) vecs.push_back(mk("up", 0, 0, 0, 1, 0, 9, k, 1, 0));
    vecs.push_back(mk("up_wrap",  0, 0, 0, 1, 0, 9, 0, 1, 1));
    vecs.push_back(mk("up_after", 0, 0, 0, 1, 0, 9, 1, 1, 0));
    // Down with load
    vecs.push_back(mk("dn_load", 0, 1, 3, 1, 1, 9, 3, 1, 0));
    vecs.push_back(mk("dn_2",    0, 0, 0, 1, 1, 9, 2, 0, 0));
    vecs.push_back(mk("dn_1",    0, 0, 0, 1, 1, 9, 1, 0, 0));
    vecs.push_back(mk("dn_0",    0, 0, 0, 1, 1, 9, 0, 0, 0));
    vecs.push_back(mk("dn_wrap", 0, 0, 0, 1, 1, 9, 9, 0, 1));
    vecs.push_back(mk("dn_8",    0, 0, 0, 1, 1, 9, 8, 0, 0));
    vecs.push_back(mk("ld_clr",  1, 1, 3, 1, 1, 9, 0, 1, 0));
    // Bounce, modulo 4
    for (int k = 0; k < 10; k++) vecs.push_back(mk("bounce", 0, 0, 0, 1, 2, 4, bc[k], bd[k], bt[k]));
    // Out-of-range load in up mode, then hold and disabled
    vecs.push_back(mk("oor_load", 0, 1, 200, 1, 0, 5, 200, 1, 0));
    vecs.push_back(mk("oor_wrap", 0, 0, 0, 1, 0, 5, 0, 1, 1));
    vecs.push_back(mk("oor_step", 0, 0, 0, 1, 0, 5, 1, 1, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk("hold", 0, 0, 0, 1, 3, 5, 1, 1, 0));
    vecs.push_back(mk("en_off", 0, 0, 0, 0, 0, 5, 1, 1, 0));
    // modulo == 0 in every mode
    vecs.push_back(mk("m0_clr",     1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("m0_up_a",    0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("m0_up_b",    0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("m0_dn",      0, 0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk("m0_bnc_rev", 0, 0, 0, 1, 2, 0, 0, 1, 1));
    vecs.push_back(mk("m0_bnc_top", 0, 0, 0, 1, 2, 0, 0, 0, 1));
    // Out-of-range in down and bounce modes
    vecs.push_back(mk("dn_oor_ld", 0, 1, 20, 1, 1, 5, 20, 0, 0));
    vecs.push_back(mk("dn_oor",    0, 0, 0,  1, 1, 5, 19, 0, 0));
    vecs.push_back(mk("b_clr",     1, 0, 0,  0, 2, 5, 0,  1, 0));
    vecs.push_back(mk("b_oor_ld",  0, 1, 10, 1, 2, 5, 10, 1, 0));
    vecs.push_back(mk("b_oor_rev", 0, 0, 0,  1, 2, 5, 9,  0, 1));
    vecs.push_back(mk("b_dn",      0, 0, 0,  1, 2, 5, 8,  0, 0));

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
    load_val = '0; mode = 2'b00; modulo = 8'd255;
`ifdef CNT_PRESCALE_EN
    presc = '0;
`endif

    #12;
    check_all("reset", 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Run to 0x37 then assert reset between edges
    en = 1'b1;
    repeat (55) edge_then_sample();
    chk("pre_reset.count", 32'(count), 32'h37);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 1, 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      clr      = vecs[i].clr;
      load     = vecs[i].load;
      load_val = vecs[i].load_val;
      en       = vecs[i].en;
      mode     = vecs[i].mode;
      modulo   = vecs[i].modulo;
      edge_then_sample();
      check_all($sformatf("%s[%0d]", vecs[i].name, i), int'(vecs[i].exp_count),
                vecs[i].exp_dir, vecs[i].exp_tc);
    end

    // tc period: one pulse every 10 steps with modulo 9
    clr = 1'b1; load = 1'b0; en = 1'b1; mode = 2'b00; modulo = 8'd9;
    edge_then_sample();
    clr = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      edge_then_sample();
      chk($sformatf("tc_period[%0d].tc", k), 32'(tc), 32'((k % 10) == 0));
      chk($sformatf("tc_period[%0d].count", k), 32'(count), 32'(k % 10));
    end

`ifdef CNT_PRESCALE_EN
    // presc=2: step on every 3rd enabled cycle; en low for 2 cycles stretches a period
    presc = 4'd2; modulo = 8'd3; mode = 2'b00;
    clr = 1'b1;
    edge_then_sample();
    clr = 1'b0; en = 1'b1;
    edge_then_sample(); chk("presc_e1.count", 32'(count), 32'd0);
    edge_then_sample(); chk("presc_e2.count", 32'(count), 32'd0);
    edge_then_sample(); chk("presc_e3.count", 32'(count), 32'd1);
    edge_then_sample(); chk("presc_e4.count", 32'(count), 32'd1);
    en = 1'b0;
    edge_then_sample(); chk("presc_off1.count", 32'(count), 32'd1);
    edge_then_sample(); chk("presc_off2.count", 32'(count), 32'd1);
    en = 1'b1;
    edge_then_sample(); chk("presc_e5.count", 32'(count), 32'd1);
    edge_then_sample(); chk("presc_e6.count", 32'(count), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
